// File: rtl/slave_xfer_ctrl_pkg.sv
// Shared types and helpers for the slave transfer controller family.
package slave_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } xfer_state_e;

  // Widest select vector is_onehot() accepts; narrower selects are zero-extended.
  localparam int MAX_SLAVES = 32;

  localparam logic XFER_OK  = 1'b0;
  localparam logic XFER_ERR = 1'b1;

  function automatic logic is_onehot(input logic [MAX_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - {{(MAX_SLAVES-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/slave_xfer_ctrl_timer.sv
// Saturating cycle counter with synchronous clear; hit flags TIMEOUT reached.
module xfer_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == CNT_MAX);

endmodule

// File: rtl/slave_xfer_ctrl.sv
// Master-to-slave transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP with
// invalid-select and timeout error completion.
module slave_xfer_ctrl
  import slave_xfer_pkg::*;
#(
  parameter int NO_OF_SLAVES = 2,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_valid,
  input  logic [NO_OF_SLAVES-1:0] m_sel,
  input  logic [DATA_W-1:0]       m_data,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [NO_OF_SLAVES-1:0] s_sel,
  output logic [DATA_W-1:0]       s_data,
  output logic [NO_OF_SLAVES-1:0] s_valid,
  input  logic [NO_OF_SLAVES-1:0] s_ready,
  output logic                    busy
);

  xfer_state_e state_q, state_d;
  logic [NO_OF_SLAVES-1:0] sel_q;
  logic [DATA_W-1:0]       data_q;
  logic                    err_q;
  logic                    sel_valid;
  logic                    sel_ready;
  logic                    timer_hit;

  assign sel_valid = is_onehot(MAX_SLAVES'(m_sel));
  // Only the addressed slave's ready counts.
  assign sel_ready = |(s_ready & sel_q);

  xfer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q == SETUP),
    .en  ((state_q == ACCESS) && !sel_ready),
    .hit (timer_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      data_q <= '0;
      err_q  <= XFER_OK;
    end else begin
      if ((state_q == IDLE) && m_valid) begin
        sel_q  <= m_sel;
        data_q <= m_data;
        err_q  <= sel_valid ? XFER_OK : XFER_ERR;
      end
      // Ready beats a simultaneous timeout.
      if (state_q == ACCESS) err_q <= sel_ready ? XFER_OK : XFER_ERR;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (m_valid) state_d = sel_valid ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timer_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_ready = 1'b0;
    m_err   = XFER_OK;
    s_sel   = '0;
    s_data  = '0;
    s_valid = '0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: ;
      SETUP: begin
        s_sel  = sel_q;
        s_data = data_q;
        busy   = 1'b1;
      end
      ACCESS: begin
        s_sel   = sel_q;
        s_data  = data_q;
        s_valid = sel_q;
        busy    = 1'b1;
      end
      RESP: begin
        m_ready = 1'b1;
        m_err   = err_q;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slave_xfer_ctrl.sv
// Directed bench for slave_xfer_ctrl; completions are checked by a scoreboard monitor.
module tb_slave_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_valid;
  logic [1:0] m_sel;
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_err;
  logic [1:0] s_sel;
  logic [7:0] s_data;
  logic [1:0] s_valid;
  logic [1:0] s_ready;
  logic       busy;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;

  exp_t       exp_q[$];
  int         edge_cnt = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  logic [1:0] allowed  = 2'b00;

  slave_xfer_ctrl #(.NO_OF_SLAVES(2), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_sel   (m_sel),
    .m_data  (m_data),
    .m_ready (m_ready),
    .m_err   (m_err),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation on every completion pulse.
  always @(negedge clk) begin
    if (m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_m_ready", 32'(m_ready), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("m_ready_cycle", 32'(edge_cnt), 32'(e.cyc));
        check("m_err", 32'(m_err), 32'(e.err));
      end
    end else if (m_err !== 1'b0) begin
      check("m_err_without_ready", 32'(m_err), 32'd0);
    end
    if (s_valid !== 2'b00) check("s_valid_only_selected", 32'(s_valid & ~allowed), 32'd0);
  end

  // ready_cyc: first cycle (relative to acceptance) the selected slave is ready.
  // other: ready bits driven on the non-selected side throughout.
  task automatic run_xfer(input logic [1:0] sel, input logic [7:0] data, input int ready_cyc,
                          input logic [1:0] other, input int exp_cyc, input logic exp_err);
    int  c;
    bit  ok_sel;
    exp_t e;
    ok_sel  = (sel == 2'b01) || (sel == 2'b10);
    c       = edge_cnt;
    m_valid = 1'b1;
    m_sel   = sel;
    m_data  = data;
    allowed = ok_sel ? sel : 2'b00;
    e.cyc   = c + exp_cyc;
    e.err   = exp_err;
    exp_q.push_back(e);
    tick();
    m_valid = 1'b0;
    m_sel   = 2'($urandom);
    m_data  = 8'($urandom);
    for (int n = 1; n <= exp_cyc; n++) begin
      s_ready = (other & ~sel) | ((n >= ready_cyc) ? sel : 2'b00);
      if (ok_sel && n == 1) begin
        check("setup_s_sel", 32'(s_sel), 32'(sel));
        check("setup_s_data", 32'(s_data), 32'(data));
        check("setup_s_valid", 32'(s_valid), 32'd0);
      end
      if (ok_sel && n == 2) begin
        check("access_s_valid", 32'(s_valid), 32'(sel));
        check("access_s_data", 32'(s_data), 32'(data));
      end
      if (!ok_sel) begin
        check("inv_s_sel", 32'(s_sel), 32'd0);
        check("inv_s_valid", 32'(s_valid), 32'd0);
      end
      if (n == exp_cyc) begin
        check("resp_s_sel", 32'(s_sel), 32'd0);
        check("resp_s_data", 32'(s_data), 32'd0);
        check("resp_s_valid", 32'(s_valid), 32'd0);
        check("resp_busy", 32'(busy), 32'd1);
      end else begin
        tick();
      end
    end
    tick();
    s_ready = 2'b00;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   c;
    rst = 1'b1; m_valid = 1'b0; m_sel = 2'b00; m_data = 8'h00; s_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_s_sel", 32'(s_sel), 32'd0);
    check("rst_s_data", 32'(s_data), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();

    run_xfer(2'b01, 8'hAB, 2, 2'b00, 3, 1'b0);    // basic
    run_xfer(2'b10, 8'h5C, 5, 2'b01, 6, 1'b0);    // delayed ready, slave 0 ready ignored
    run_xfer(2'b00, 8'h33, 99, 2'b00, 1, 1'b1);   // no select
    run_xfer(2'b11, 8'h44, 99, 2'b00, 1, 1'b1);   // multi-hot select
    run_xfer(2'b01, 8'h9D, 99, 2'b00, 19, 1'b1);  // timeout
    run_xfer(2'b01, 8'h9E, 17, 2'b00, 18, 1'b0);  // ready in 16th ACCESS cycle
    run_xfer(2'b01, 8'h9F, 18, 2'b00, 19, 1'b0);  // ready on the timeout cycle wins

    // Reset during the second ACCESS cycle.
    c = edge_cnt;
    m_valid = 1'b1; m_sel = 2'b01; m_data = 8'h77; allowed = 2'b01; s_ready = 2'b00;
    tick();
    m_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_s_valid", 32'(s_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_ready", 32'(m_ready), 32'd0);
    check("midrst_s_sel", 32'(s_sel), 32'd0);
    check("midrst_s_data", 32'(s_data), 32'd0);
    check("midrst_s_valid", 32'(s_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    run_xfer(2'b10, 8'hC3, 2, 2'b00, 3, 1'b0);

    // Back-to-back with m_valid held; select change during ACCESS is ignored.
    c = edge_cnt;
    m_valid = 1'b1; m_sel = 2'b01; m_data = 8'h11; s_ready = 2'b11; allowed = 2'b01;
    e.cyc = c + 3; e.err = 1'b0; exp_q.push_back(e);
    e.cyc = c + 7; e.err = 1'b0; exp_q.push_back(e);
    tick();
    check("b2b_setup1_s_sel", 32'(s_sel), 32'h1);
    tick();
    m_sel = 2'b10; m_data = 8'h22;
    check("b2b_hold_s_sel", 32'(s_sel), 32'h1);
    check("b2b_hold_s_data", 32'(s_data), 32'h11);
    tick();
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    tick();
    check("b2b_setup2_s_sel", 32'(s_sel), 32'h2);
    check("b2b_setup2_s_data", 32'(s_data), 32'h22);
    allowed = 2'b10;
    m_valid = 1'b0;
    repeat (3) tick();
    s_ready = 2'b00;
    repeat (3) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
